// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encodings and the
// processor instruction width.
package instruction_sequencer_pkg;

    localparam int SEQ_DATA_W = 8;

    typedef enum logic [1:0] {
        SEQ_LOAD  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/instr_buffer.sv
// Program storage: DEPTH x DATA_W register array, synchronous write and
// asynchronous read. Contents are not reset.
module instr_buffer
    import instruction_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = SEQ_DATA_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        always_ff @(posedge clock) begin
            if (we && (waddr == ADDR_W'(i))) mem[i] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Feeds the processor's instruction port from a loaded program buffer, one
// instruction per completion handshake, halting after the last one.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = SEQ_DATA_W
) (
    input  logic              clock,
    input  logic              resetnot,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              run,
    input  logic              step_done,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              halted,
    output logic [1:0]        state
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ovf_q, ovf_d;
    logic              we, load_instr;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] rdata;

    assign waddr = count_q[ADDR_W-1:0];
    assign raddr = pc_d;

    instr_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            state_q <= SEQ_LOAD;
            pc_q    <= '0;
            count_q <= '0;
            instr_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        we         = 1'b0;
        load_instr = 1'b0;
        if (clear) begin
            state_d = SEQ_LOAD;
            pc_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                SEQ_LOAD: begin
                    if (wr_en) begin
                        if (count_q != FULL_CNT) begin
                            we      = 1'b1;
                            count_d = count_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    // run sees the post-write count so a same-cycle write is included
                    if (run && (count_d != '0)) begin
                        pc_d       = '0;
                        state_d    = SEQ_ISSUE;
                        load_instr = 1'b1;
                    end
                end
                SEQ_ISSUE: state_d = SEQ_WAIT;
                SEQ_WAIT: begin
                    if (step_done) begin
                        if (({1'b0, pc_q} + 1'b1) == count_q) begin
                            state_d = SEQ_HALT;
                        end else begin
                            pc_d       = pc_q + 1'b1;
                            state_d    = SEQ_ISSUE;
                            load_instr = 1'b1;
                        end
                    end
                end
                SEQ_HALT: begin
                    if (run) begin
                        pc_d       = '0;
                        state_d    = SEQ_ISSUE;
                        load_instr = 1'b1;
                    end
                end
            endcase
        end
    end

    // Forward the write data when the slot being fetched is written this cycle
    always_comb begin
        instr_d = instr_q;
        if (load_instr) instr_d = (we && (waddr == raddr)) ? wr_data : rdata;
    end

    assign instruction = instr_q;
    assign instr_valid = (state_q == SEQ_ISSUE);
    assign pc          = pc_q;
    assign count       = count_q;
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign overflow    = ovf_q;
    assign halted      = (state_q == SEQ_HALT);
    assign state       = state_q;

endmodule
